// File: rtl/sb_tx_scheduler.sv
// Sideband TX scheduler: round-robin arbitration of N_REQ message sources
// onto the single SB TX valid/ack port, gated by a credit count that mirrors
// the SB TX buffer depth.
//
// Handshake: sb_valid_o rises with sb_data_o one cycle after a grant, and both
// stay stable until the cycle in which sb_ack_i is sampled high in SEND. The
// requester's req_ack_o pulses for one cycle after that. A turnaround cycle
// with sb_valid_o low always follows. req_valid_i must be held until
// req_ack_o. sb_ack_i is ignored outside SEND.
module sb_tx_scheduler #(
  parameter int N_REQ       = 4,
  parameter int CREDITS     = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                           clk_800MHz,
  input  logic                           reset,
  input  logic                           enable_i,
  input  logic [N_REQ-1:0]               req_valid_i,
  input  logic [64*N_REQ-1:0]            req_data_i,
  output logic [N_REQ-1:0]               req_ack_o,
  output logic                           sb_valid_o,
  output logic [63:0]                    sb_data_o,
  input  logic                           sb_ack_i,
  output logic                           sb_enable_o,
  input  logic                           credit_return_i,
  output logic                           busy_o,
  output logic [$clog2(CREDITS+1)-1:0]   credits_o,
  output logic                           timeout_err_o,
  output logic                           credit_err_o,
  output logic [1:0]                     dbg_state_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SUM_W = PTR_W + 1;
  localparam int CNT_W = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] CREDITS_MAX = CNT_W'(CREDITS);
  // Last SEND cycle index before giving up on the ack.
  localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_winner;
  logic [7:0]         r_wait;
  logic               r_sb_valid;
  logic [63:0]        r_sb_data;
  logic [N_REQ-1:0]   r_req_ack;
  logic               r_sb_enable;
  logic               r_busy;
  logic [CNT_W-1:0]   r_credits;
  logic               r_timeout_err;
  logic               r_credit_err;

  logic               w_found;
  logic [PTR_W-1:0]   w_grant_idx;
  logic [SUM_W-1:0]   w_sum;
  logic [63:0]        w_grant_data;
  logic               w_grant;
  logic               w_ack_take;
  logic [PTR_W-1:0]   w_next_ptr;

  // Round-robin search: first pending requester at or after r_rr_ptr.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_sum       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + SUM_W'(i);
      if (w_sum >= SUM_W'(N_REQ)) begin
        w_sum = w_sum - SUM_W'(N_REQ);
      end
      if (!w_found && req_valid_i[PTR_W'(w_sum)]) begin
        w_found     = 1'b1;
        w_grant_idx = PTR_W'(w_sum);
      end
    end
  end

  assign w_grant_data = req_data_i[int'(w_grant_idx) * 64 +: 64];
  assign w_grant      = enable_i && (r_credits != '0) && w_found;
  assign w_ack_take   = (r_state == ST_SEND) && sb_ack_i;
  assign w_next_ptr   = (r_winner == PTR_W'(N_REQ - 1)) ? '0 : r_winner + PTR_W'(1);

  // Main FSM: grant in IDLE, hold the message in SEND, one turnaround in GAP.
  always_ff @(posedge clk_800MHz) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= '0;
      r_winner      <= '0;
      r_wait        <= '0;
      r_sb_valid    <= 1'b0;
      r_sb_data     <= '0;
      r_req_ack     <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_req_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_winner   <= w_grant_idx;
            r_sb_data  <= w_grant_data;
            r_sb_valid <= 1'b1;
            r_wait     <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (sb_ack_i) begin
            r_sb_valid           <= 1'b0;
            r_req_ack[r_winner]  <= 1'b1;
            r_rr_ptr             <= w_next_ptr;
            r_state              <= ST_GAP;
          end else if (r_wait == WAIT_LAST) begin
            // Abandon the message; the requester stays pending and is
            // re-arbitrated after the others get a turn.
            r_sb_valid    <= 1'b0;
            r_timeout_err <= 1'b1;
            r_rr_ptr      <= w_next_ptr;
            r_state       <= ST_GAP;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        ST_GAP: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_sb_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  // Credit counter: acked messages consume, serializer returns refill.
  always_ff @(posedge clk_800MHz) begin
    if (!reset) begin
      r_credits    <= CREDITS_MAX;
      r_credit_err <= 1'b0;
    end else if (credit_return_i && !w_ack_take) begin
      if (r_credits == CREDITS_MAX) begin
        r_credit_err <= 1'b1;
      end else begin
        r_credits <= r_credits + CNT_W'(1);
      end
    end else if (w_ack_take && !credit_return_i) begin
      if (r_credits != '0) begin
        r_credits <= r_credits - CNT_W'(1);
      end
    end
  end

  // SB TX buffer write enable follows enable_i by one cycle.
  always_ff @(posedge clk_800MHz) begin
    if (!reset) begin
      r_sb_enable <= 1'b0;
    end else begin
      r_sb_enable <= enable_i;
    end
  end

  assign req_ack_o     = r_req_ack;
  assign sb_valid_o    = r_sb_valid;
  assign sb_data_o     = r_sb_data;
  assign sb_enable_o   = r_sb_enable;
  assign busy_o        = r_busy;
  assign credits_o     = r_credits;
  assign timeout_err_o = r_timeout_err;
  assign credit_err_o  = r_credit_err;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_sb_tx_scheduler.sv
// Directed bench for sb_tx_scheduler with requester, SB TX ack and credit
// return agents folded into a single per-cycle tick task.
module tb_sb_tx_scheduler;
  localparam int N_REQ = 4;
  localparam int CREDITS = 4;
  localparam int ACK_TIMEOUT = 8;

  logic                  clk;
  logic                  reset;
  logic                  enable_i;
  logic [N_REQ-1:0]      req_valid_i;
  logic [64*N_REQ-1:0]   req_data_i;
  logic [N_REQ-1:0]      req_ack_o;
  logic                  sb_valid_o;
  logic [63:0]           sb_data_o;
  logic                  sb_ack_i;
  logic                  sb_enable_o;
  logic                  credit_return_i;
  logic                  busy_o;
  logic [2:0]            credits_o;
  logic                  timeout_err_o;
  logic                  credit_err_o;
  logic [1:0]            dbg_state_o;

  sb_tx_scheduler #(
    .N_REQ(N_REQ), .CREDITS(CREDITS), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk_800MHz(clk), .reset(reset), .enable_i(enable_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ack_o(req_ack_o),
    .sb_valid_o(sb_valid_o), .sb_data_o(sb_data_o), .sb_ack_i(sb_ack_i),
    .sb_enable_o(sb_enable_o), .credit_return_i(credit_return_i),
    .busy_o(busy_o), .credits_o(credits_o), .timeout_err_o(timeout_err_o),
    .credit_err_o(credit_err_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // scoreboard and agent state
  logic [63:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int ack_cnt[N_REQ];
  int rem[N_REQ];
  int msg[N_REQ];
  int grants;
  logic prev_valid;
  int ack_lat;
  int wcnt;
  bit auto_ret, man_ret, ret_with_ack;
  logic [63:0] exp_d;
  int cnt;

  function automatic logic [63:0] mkdata(input int k, input int m);
    return 64'hA5A5_0000_0000_0000 | (64'(m) << 16) | 64'(k + 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at negedge, score new grants, run agents.
  task automatic tick();
    @(negedge clk);
    if (sb_valid_o && !prev_valid) begin
      grants++;
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL grant_extra observed=%0h expected=none", sb_data_o);
      end
      if (exp_q.size() > 0) begin
        exp_d = exp_q.pop_front();
        chk("grant_data", sb_data_o, exp_d);
      end
    end
    prev_valid = sb_valid_o;
    for (int k = 0; k < N_REQ; k++) begin
      if (req_ack_o[k]) begin
        ack_cnt[k]++;
        msg[k]++;
        if (rem[k] > 0) rem[k]--;
        if (rem[k] > 0) req_data_i[64*k +: 64] = mkdata(k, msg[k]);
        else req_valid_i[k] = 1'b0;
      end
    end
    credit_return_i = (auto_ret && (req_ack_o != '0)) || man_ret;
    man_ret = 1'b0;
    if (ack_lat >= 0 && sb_valid_o && !sb_ack_i) begin
      if (wcnt >= ack_lat) begin
        sb_ack_i = 1'b1;
        if (ret_with_ack) credit_return_i = 1'b1;
      end else begin
        wcnt++;
      end
    end else begin
      sb_ack_i = 1'b0;
      wcnt = 0;
    end
  endtask

  task automatic start_req(input int k, input int n);
    rem[k] = n;
    req_data_i[64*k +: 64] = mkdata(k, msg[k]);
    req_valid_i[k] = 1'b1;
  endtask

  task automatic wait_acks(input int k, input int n, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (ack_cnt[k] >= n) break;
      tick();
    end
    chk(tag, 64'(ack_cnt[k]), 64'(n));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sb_valid"}, 64'(sb_valid_o), 64'd0);
    chk({tag, "_sb_data"}, sb_data_o, 64'd0);
    chk({tag, "_req_ack"}, 64'(req_ack_o), 64'd0);
    chk({tag, "_sb_enable"}, 64'(sb_enable_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_credits"}, 64'(credits_o), 64'd4);
  endtask

  task automatic do_reset(input bit check);
    reset = 1'b0;
    enable_i = 1'b0;
    sb_ack_i = 1'b0;
    credit_return_i = 1'b0;
    req_valid_i = '0;
    req_data_i = '0;
    ack_lat = -1;
    auto_ret = 1'b0;
    man_ret = 1'b0;
    ret_with_ack = 1'b0;
    for (int k = 0; k < N_REQ; k++) rem[k] = 0;
    repeat (3) tick();
    if (check) begin
      check_reset_vals("reset");
      chk("reset_timeout_err", 64'(timeout_err_o), 64'd0);
      chk("reset_credit_err", 64'(credit_err_o), 64'd0);
    end
    for (int k = 0; k < N_REQ; k++) ack_cnt[k] = 0;
    grants = 0;
    reset = 1'b1;
    enable_i = 1'b1;
    tick();
    if (check) chk("sb_enable_follow", 64'(sb_enable_o), 64'd1);
  endtask

  initial begin
    prev_valid = 1'b0;
    wcnt = 0;
    for (int k = 0; k < N_REQ; k++) msg[k] = 0;

    // single requester, ack two cycles after valid
    do_reset(1'b1);
    ack_lat = 2;
    exp_q.push_back(mkdata(0, msg[0]));
    start_req(0, 1);
    tick();
    chk("s1_latency", 64'(sb_valid_o), 64'd1);
    chk("s1_busy_send", 64'(busy_o), 64'd1);
    wait_acks(0, 1, 50, "s1_ack");
    repeat (3) tick();
    chk("s1_ack_once", 64'(ack_cnt[0]), 64'd1);
    chk("s1_credits", 64'(credits_o), 64'd3);
    chk("s1_busy_idle", 64'(busy_o), 64'd0);

    // all four requesting, immediate ack, credits returned
    do_reset(1'b0);
    ack_lat = 0;
    auto_ret = 1'b1;
    exp_q.push_back(mkdata(0, msg[0]));
    exp_q.push_back(mkdata(1, msg[1]));
    exp_q.push_back(mkdata(2, msg[2]));
    exp_q.push_back(mkdata(3, msg[3]));
    exp_q.push_back(mkdata(0, msg[0] + 1));
    exp_q.push_back(mkdata(1, msg[1] + 1));
    start_req(0, 2); start_req(1, 2); start_req(2, 1); start_req(3, 1);
    wait_acks(1, 2, 200, "s2_last_ack");
    repeat (5) tick();
    chk("s2_ack0", 64'(ack_cnt[0]), 64'd2);
    chk("s2_ack2", 64'(ack_cnt[2]), 64'd1);
    chk("s2_ack3", 64'(ack_cnt[3]), 64'd1);
    chk("s2_credits", 64'(credits_o), 64'd4);
    chk("s2_pending", 64'(exp_q.size()), 64'd0);

    // no credit returns: four grants then blocked; one return -> one grant
    do_reset(1'b0);
    ack_lat = 0;
    for (int k = 0; k < N_REQ; k++) exp_q.push_back(mkdata(k, msg[k]));
    for (int k = 0; k < N_REQ; k++) start_req(k, 2);
    wait_acks(3, 1, 200, "s3_fourth_ack");
    repeat (10) tick();
    chk("s3_grants", 64'(grants), 64'd4);
    chk("s3_valid_blocked", 64'(sb_valid_o), 64'd0);
    chk("s3_credits_zero", 64'(credits_o), 64'd0);
    exp_q.push_back(mkdata(0, msg[0]));
    man_ret = 1'b1;
    wait_acks(0, 2, 50, "s3_extra_ack");
    repeat (10) tick();
    chk("s3_grants_after", 64'(grants), 64'd5);
    chk("s3_valid_after", 64'(sb_valid_o), 64'd0);
    chk("s3_credits_after", 64'(credits_o), 64'd0);

    // ack timeout, then next requester gets the grant
    do_reset(1'b0);
    exp_q.push_back(mkdata(0, msg[0]));
    exp_q.push_back(mkdata(1, msg[1]));
    exp_q.push_back(mkdata(0, msg[0]));
    start_req(0, 1); start_req(1, 1);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (sb_valid_o) cnt++;
      else if (cnt > 0) break;
    end
    chk("s4_send_cycles", 64'(cnt), 64'd8);
    chk("s4_timeout_err", 64'(timeout_err_o), 64'd1);
    chk("s4_credits", 64'(credits_o), 64'd4);
    chk("s4_no_ack", 64'(ack_cnt[0]), 64'd0);
    ack_lat = 0;
    wait_acks(1, 1, 50, "s4_next_req");
    chk("s4_first_not_acked", 64'(ack_cnt[0]), 64'd0);
    wait_acks(0, 1, 50, "s4_retry");
    chk("s4_timeout_sticky", 64'(timeout_err_o), 64'd1);

    // credit overflow, simultaneous ack and return
    do_reset(1'b0);
    man_ret = 1'b1;
    tick();
    tick();
    chk("s5_credits_sat", 64'(credits_o), 64'd4);
    chk("s5_credit_err", 64'(credit_err_o), 64'd1);
    ack_lat = 0;
    exp_q.push_back(mkdata(0, msg[0]));
    exp_q.push_back(mkdata(0, msg[0] + 1));
    start_req(0, 2);
    wait_acks(0, 2, 100, "s5_two_acks");
    tick();
    chk("s5_credits_two", 64'(credits_o), 64'd2);
    ret_with_ack = 1'b1;
    exp_q.push_back(mkdata(1, msg[1]));
    start_req(1, 1);
    wait_acks(1, 1, 50, "s5_simul_ack");
    ret_with_ack = 1'b0;
    repeat (2) tick();
    chk("s5_credits_hold", 64'(credits_o), 64'd2);

    // reset in the middle of SEND
    do_reset(1'b0);
    exp_q.push_back(mkdata(2, msg[2]));
    exp_q.push_back(mkdata(2, msg[2]));
    start_req(2, 1);
    tick();
    tick();
    chk("s6_in_send", 64'(busy_o), 64'd1);
    reset = 1'b0;
    tick();
    check_reset_vals("s6_midreset");
    reset = 1'b1;
    tick();
    chk("s6_regrant", 64'(sb_valid_o), 64'd1);
    ack_lat = 0;
    wait_acks(2, 1, 50, "s6_ack");
    repeat (3) tick();
    chk("s6_credits", 64'(credits_o), 64'd3);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
